pe_ctrl_sequencer: RTL and testbench

Command-driven controller that drives the control interface of one reconfigurable PE (or a PE row sharing control).
- Accepts a dataflow command: mode plus load, compute and drain phase lengths.
- Steps through LOAD -> COMPUTE -> DRAIN.
- Per phase, drives the eight 2-bit crossbar selects, the output mux select, mac_enable, accum_clear and output_stationary_enable.
- Sits between the array-level scheduler and the PE grid; it is the initiator side of the PE control interface.

---
 rtl/pe_ctrl_pkg.sv | 66 ++++++
 rtl/pe_ctrl_sequencer_decode.sv | 47 ++++
 rtl/pe_ctrl_sequencer.sv | 154 +++++++++++++++
 tb/tb_pe_ctrl_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_ctrl_pkg.sv
// Shared types and constants for the PE control sequencer.
// Holds mode/state encodings, crossbar words and output mux selects.
// No logic; imported by the sequencer top and its output decoder.
package pe_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_WS     = 2'd0,
        MODE_OS     = 2'd1,
        MODE_IS     = 2'd2,
        MODE_BYPASS = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    // Externally visible phase code; IDLE and DONE both report 0.
    localparam logic [1:0] PHASE_IDLE    = 2'd0;
    localparam logic [1:0] PHASE_LOAD    = 2'd1;
    localparam logic [1:0] PHASE_COMPUTE = 2'd2;
    localparam logic [1:0] PHASE_DRAIN   = 2'd3;

    localparam int XBAR_W = 16;

    localparam logic [1:0] CB_STRAIGHT = 2'b00;
    localparam logic [1:0] CB_SWAP     = 2'b01;

    // Crossbar words, crossbar 7 leftmost, crossbar 0 rightmost.
    localparam logic [XBAR_W-1:0] XBAR_STRAIGHT   = {8{CB_STRAIGHT}};
    localparam logic [XBAR_W-1:0] XBAR_OS_COMPUTE = {{2{CB_STRAIGHT}}, CB_SWAP, {5{CB_STRAIGHT}}};
    localparam logic [XBAR_W-1:0] XBAR_IS_COMPUTE = {{4{CB_STRAIGHT}}, CB_SWAP, CB_SWAP, {2{CB_STRAIGHT}}};
    localparam logic [XBAR_W-1:0] XBAR_BY_COMPUTE = {CB_SWAP, {7{CB_STRAIGHT}}};
    localparam logic [XBAR_W-1:0] XBAR_OS_DRAIN   = {{5{CB_STRAIGHT}}, CB_SWAP, {2{CB_STRAIGHT}}};

    localparam logic [1:0] MUX_IDLE    = 2'b00;
    localparam logic [1:0] MUX_COMPUTE = 2'b00;
    localparam logic [1:0] MUX_DRAIN   = 2'b01;
    localparam logic [1:0] MUX_LOAD    = 2'b11;

    function automatic logic [XBAR_W-1:0] compute_xbar(input mode_e mode);
        case (mode)
            MODE_OS:     return XBAR_OS_COMPUTE;
            MODE_IS:     return XBAR_IS_COMPUTE;
            MODE_BYPASS: return XBAR_BY_COMPUTE;
            default:     return XBAR_STRAIGHT;
        endcase
    endfunction

    function automatic logic [XBAR_W-1:0] drain_xbar(input mode_e mode);
        return (mode == MODE_OS) ? XBAR_OS_DRAIN : XBAR_STRAIGHT;
    endfunction

    function automatic logic [1:0] phase_of(input state_e st);
        case (st)
            ST_LOAD:    return PHASE_LOAD;
            ST_COMPUTE: return PHASE_COMPUTE;
            ST_DRAIN:   return PHASE_DRAIN;
            default:    return PHASE_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/pe_ctrl_sequencer_decode.sv
// Combinational decode of sequencer state/mode into PE control outputs.
// Latency: zero (pure combinational).
// Backpressure: stall gates the enables and the clear pulse; selects hold.
module pe_ctrl_sequencer_decode
    import pe_ctrl_pkg::*;
(
    input  state_e            state,
    input  mode_e             mode,
    input  logic              first_cycle,
    input  logic              stall,
    output logic [XBAR_W-1:0] xbar,
    output logic [1:0]        mux_sel,
    output logic              mac_enable,
    output logic              accum_clear,
    output logic              output_stationary_enable
);

    // Per-phase control word; enables and clear are masked while stalled.
    always_comb begin
        xbar                     = XBAR_STRAIGHT;
        mux_sel                  = MUX_IDLE;
        mac_enable               = 1'b0;
        accum_clear              = 1'b0;
        output_stationary_enable = 1'b0;
        case (state)
            ST_LOAD: begin
                mux_sel     = MUX_LOAD;
                mac_enable  = ((mode == MODE_WS) || (mode == MODE_IS)) && !stall;
                accum_clear = first_cycle && (mode == MODE_OS) && !stall;
            end
            ST_COMPUTE: begin
                xbar                     = compute_xbar(mode);
                mux_sel                  = MUX_COMPUTE;
                mac_enable               = (mode != MODE_BYPASS) && !stall;
                output_stationary_enable = (mode == MODE_OS) && !stall;
            end
            ST_DRAIN: begin
                xbar    = drain_xbar(mode);
                mux_sel = MUX_DRAIN;
            end
            default: begin
                xbar = XBAR_STRAIGHT;
            end
        endcase
    end

endmodule

// File: rtl/pe_ctrl_sequencer.sv
// Sequences one dataflow command through LOAD -> COMPUTE -> DRAIN -> DONE.
// Latency: first phase starts the cycle after accept; each phase lasts its length.
// Backpressure: cmd_ready only in IDLE; stall freezes state and counter.
module pe_ctrl_sequencer
    import pe_ctrl_pkg::*;
#(
    parameter int CNT_W  = 8,
    parameter int NUM_CB = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_mode,
    input  logic [CNT_W-1:0]    cmd_load_len,
    input  logic [CNT_W-1:0]    cmd_k_len,
    input  logic [CNT_W-1:0]    cmd_drain_len,
    input  logic                stall,
    output logic [2*NUM_CB-1:0] ctrl_crossbar,
    output logic [1:0]          mux_sel,
    output logic                mac_enable,
    output logic                accum_clear,
    output logic                output_stationary_enable,
    output logic                busy,
    output logic                done,
    output logic [1:0]          phase
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    mode_e            mode_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] k_len_q, drain_len_q;
    logic             first_q, first_d;
    logic             accept;

    // First phase with a nonzero length, in LOAD/COMPUTE/DRAIN order.
    function automatic state_e pick_phase(input logic [CNT_W-1:0] l, k, d);
        if (l != '0)      return ST_LOAD;
        else if (k != '0) return ST_COMPUTE;
        else if (d != '0) return ST_DRAIN;
        else              return ST_DONE;
    endfunction

    // Counter preload for the phase chosen by pick_phase.
    function automatic logic [CNT_W-1:0] pick_len(input logic [CNT_W-1:0] l, k, d);
        if (l != '0)      return l - CNT_ONE;
        else if (k != '0) return k - CNT_ONE;
        else if (d != '0) return d - CNT_ONE;
        else              return '0;
    endfunction

    assign cmd_ready = (state_q == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // Next state, counter and first-LOAD-cycle flag.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        first_d = first_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = pick_phase(cmd_load_len, cmd_k_len, cmd_drain_len);
                    cnt_d   = pick_len(cmd_load_len, cmd_k_len, cmd_drain_len);
                end
            end
            ST_LOAD: begin
                if (!stall) begin
                    first_d = 1'b0;
                    if (cnt_q == '0) begin
                        state_d = pick_phase('0, k_len_q, drain_len_q);
                        cnt_d   = pick_len('0, k_len_q, drain_len_q);
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            ST_COMPUTE: begin
                if (!stall) begin
                    if (cnt_q == '0) begin
                        state_d = pick_phase('0, '0, drain_len_q);
                        cnt_d   = pick_len('0, '0, drain_len_q);
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            ST_DRAIN: begin
                if (!stall) begin
                    if (cnt_q == '0) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            ST_DONE: begin
                if (!stall) state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Arm the clear pulse whenever LOAD is entered.
        if ((state_d == ST_LOAD) && (state_q != ST_LOAD)) first_d = 1'b1;
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

    // Command fields captured on accept only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q      <= MODE_WS;
            k_len_q     <= '0;
            drain_len_q <= '0;
        end else if (accept) begin
            mode_q      <= mode_e'(cmd_mode);
            k_len_q     <= cmd_k_len;
            drain_len_q <= cmd_drain_len;
        end
    end

    pe_ctrl_sequencer_decode u_decode (
        .state                    (state_q),
        .mode                     (mode_q),
        .first_cycle              (first_q),
        .stall                    (stall),
        .xbar                     (ctrl_crossbar),
        .mux_sel                  (mux_sel),
        .mac_enable               (mac_enable),
        .accum_clear              (accum_clear),
        .output_stationary_enable (output_stationary_enable)
    );

    assign busy  = (state_q != ST_IDLE);
    assign done  = (state_q == ST_DONE);
    assign phase = phase_of(state_q);

endmodule

// File: tb/tb_pe_ctrl_sequencer.sv
// Directed, table-driven bench for pe_ctrl_sequencer.
// Each table row is one clock cycle: inputs held that cycle, expected outputs.
// Reset-mid-command and the follow-up BYPASS command are hand sequenced.
module tb_pe_ctrl_sequencer;

    typedef struct packed {
        logic        rdy;
        logic        bsy;
        logic        dn;
        logic [1:0]  ph;
        logic [15:0] xb;
        logic [1:0]  mx;
        logic        mac;
        logic        clr;
        logic        ose;
    } out_t;

    typedef struct packed {
        logic       vld;
        logic [1:0] md;
        logic [7:0] l;
        logic [7:0] k;
        logic [7:0] d;
        logic       st;
        out_t       exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_mode;
    logic [7:0]  cmd_load_len, cmd_k_len, cmd_drain_len;
    logic        stall;
    logic [15:0] ctrl_crossbar;
    logic [1:0]  mux_sel;
    logic        mac_enable, accum_clear, output_stationary_enable;
    logic        busy, done;
    logic [1:0]  phase;

    int   n_pass  = 0;
    int   n_total = 0;
    vec_t vecs[$];
    out_t idle_o, done_o;

    pe_ctrl_sequencer #(.CNT_W(8), .NUM_CB(8)) dut (
        .clk                      (clk),
        .reset                    (reset),
        .cmd_valid                (cmd_valid),
        .cmd_ready                (cmd_ready),
        .cmd_mode                 (cmd_mode),
        .cmd_load_len             (cmd_load_len),
        .cmd_k_len                (cmd_k_len),
        .cmd_drain_len            (cmd_drain_len),
        .stall                    (stall),
        .ctrl_crossbar            (ctrl_crossbar),
        .mux_sel                  (mux_sel),
        .mac_enable               (mac_enable),
        .accum_clear              (accum_clear),
        .output_stationary_enable (output_stationary_enable),
        .busy                     (busy),
        .done                     (done),
        .phase                    (phase)
    );

    always #5 clk = ~clk;

    function automatic out_t o(input logic rdy, bsy, dn, input logic [1:0] ph,
                               input logic [15:0] xb, input logic [1:0] mx,
                               input logic mac, clr, ose);
        out_t r;
        r.rdy = rdy; r.bsy = bsy; r.dn = dn; r.ph = ph; r.xb = xb;
        r.mx = mx; r.mac = mac; r.clr = clr; r.ose = ose;
        return r;
    endfunction

    function automatic out_t cur();
        return o(cmd_ready, busy, done, phase, ctrl_crossbar, mux_sel,
                 mac_enable, accum_clear, output_stationary_enable);
    endfunction

    task automatic r(input logic vld, input logic [1:0] md, input logic [7:0] l, k, d,
                     input logic st, input out_t exp);
        vec_t v;
        v.vld = vld; v.md = md; v.l = l; v.k = k; v.d = d; v.st = st; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input out_t got, input out_t exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got rdy=%b bsy=%b done=%b ph=%0d xb=%h mx=%b mac=%b clr=%b ose=%b, want rdy=%b bsy=%b done=%b ph=%0d xb=%h mx=%b mac=%b clr=%b ose=%b",
                     name, got.rdy, got.bsy, got.dn, got.ph, got.xb, got.mx, got.mac, got.clr, got.ose,
                     exp.rdy, exp.bsy, exp.dn, exp.ph, exp.xb, exp.mx, exp.mac, exp.clr, exp.ose);
        else
            n_pass++;
    endtask

    task automatic drive(input logic vld, input logic [1:0] md, input logic [7:0] l, k, d,
                         input logic st);
        cmd_valid = vld; cmd_mode = md; cmd_load_len = l;
        cmd_k_len = k; cmd_drain_len = d; stall = st;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        out_t ws_load, ws_comp, ws_drain, os_load, os_load_clr, os_comp, os_drain;
        out_t is_comp, comp_stalled, load_stalled, by_comp;

        idle_o       = o(1, 0, 0, 2'd0, 16'h0000, 2'b00, 0, 0, 0);
        done_o       = o(0, 1, 1, 2'd0, 16'h0000, 2'b00, 0, 0, 0);
        ws_load      = o(0, 1, 0, 2'd1, 16'h0000, 2'b11, 1, 0, 0);
        ws_comp      = o(0, 1, 0, 2'd2, 16'h0000, 2'b00, 1, 0, 0);
        ws_drain     = o(0, 1, 0, 2'd3, 16'h0000, 2'b01, 0, 0, 0);
        os_load      = o(0, 1, 0, 2'd1, 16'h0000, 2'b11, 0, 0, 0);
        os_load_clr  = o(0, 1, 0, 2'd1, 16'h0000, 2'b11, 0, 1, 0);
        os_comp      = o(0, 1, 0, 2'd2, 16'h0400, 2'b00, 1, 0, 1);
        os_drain     = o(0, 1, 0, 2'd3, 16'h0010, 2'b01, 0, 0, 0);
        is_comp      = o(0, 1, 0, 2'd2, 16'h0050, 2'b00, 1, 0, 0);
        comp_stalled = o(0, 1, 0, 2'd2, 16'h0000, 2'b00, 0, 0, 0);
        load_stalled = o(0, 1, 0, 2'd1, 16'h0000, 2'b11, 0, 0, 0);
        by_comp      = o(0, 1, 0, 2'd2, 16'h4000, 2'b00, 0, 0, 0);

        // WS load=2 k=3 drain=1
        r(1, 0, 2, 3, 1, 0, idle_o);
        r(0, 0, 0, 0, 0, 0, ws_load);
        r(0, 0, 0, 0, 0, 0, ws_load);
        for (int i = 0; i < 3; i++) r(0, 0, 0, 0, 0, 0, ws_comp);
        r(0, 0, 0, 0, 0, 0, ws_drain);
        r(0, 0, 0, 0, 0, 0, done_o);
        r(0, 0, 0, 0, 0, 0, idle_o);
        // OS load=1 k=4 drain=2: clear on the single LOAD cycle
        r(1, 1, 1, 4, 2, 0, idle_o);
        r(0, 0, 0, 0, 0, 0, os_load_clr);
        for (int i = 0; i < 4; i++) r(0, 0, 0, 0, 0, 0, os_comp);
        r(0, 0, 0, 0, 0, 0, os_drain);
        r(0, 0, 0, 0, 0, 0, os_drain);
        r(0, 0, 0, 0, 0, 0, done_o);
        r(0, 0, 0, 0, 0, 0, idle_o);
        // IS load=0 k=2 drain=0: straight to COMPUTE
        r(1, 2, 0, 2, 0, 0, idle_o);
        r(0, 0, 0, 0, 0, 0, is_comp);
        r(0, 0, 0, 0, 0, 0, is_comp);
        r(0, 0, 0, 0, 0, 0, done_o);
        r(0, 0, 0, 0, 0, 0, idle_o);
        // All lengths zero: DONE right after accept
        r(1, 0, 0, 0, 0, 0, idle_o);
        r(0, 0, 0, 0, 0, 0, done_o);
        r(0, 0, 0, 0, 0, 0, idle_o);
        // WS k=4 with a 3-cycle stall mid COMPUTE: 7 COMPUTE cycles, 4 with mac
        r(1, 0, 0, 4, 0, 0, idle_o);
        r(0, 0, 0, 0, 0, 0, ws_comp);
        r(0, 0, 0, 0, 0, 0, ws_comp);
        for (int i = 0; i < 3; i++) r(0, 0, 0, 0, 0, 1, comp_stalled);
        r(0, 0, 0, 0, 0, 0, ws_comp);
        r(0, 0, 0, 0, 0, 0, ws_comp);
        r(0, 0, 0, 0, 0, 0, done_o);
        r(0, 0, 0, 0, 0, 0, idle_o);
        // OS load=2 k=1: stalled first LOAD cycle defers the clear; stall in DONE
        r(1, 1, 2, 1, 0, 0, idle_o);
        r(0, 0, 0, 0, 0, 1, load_stalled);
        r(0, 0, 0, 0, 0, 0, os_load_clr);
        r(0, 0, 0, 0, 0, 0, os_load);
        r(0, 0, 0, 0, 0, 0, os_comp);
        r(0, 0, 0, 0, 0, 1, done_o);
        r(0, 0, 0, 0, 0, 0, done_o);
        // Stall in IDLE still accepts (IS k=1)
        r(1, 2, 0, 1, 0, 1, idle_o);
        r(0, 0, 0, 0, 0, 0, is_comp);
        r(0, 0, 0, 0, 0, 0, done_o);
        r(0, 0, 0, 0, 0, 0, idle_o);
        // cmd_valid held high, mode/lengths wiggled while busy
        r(1, 0, 1, 1, 1, 0, idle_o);
        r(1, 1, 1, 1, 1, 0, ws_load);
        r(1, 3, 5, 5, 5, 0, ws_comp);
        r(1, 1, 0, 1, 0, 0, ws_drain);
        r(1, 1, 0, 1, 0, 0, done_o);
        r(1, 1, 0, 1, 0, 0, idle_o);
        r(0, 0, 0, 0, 0, 0, os_comp);
        r(0, 0, 0, 0, 0, 0, done_o);
        r(0, 0, 0, 0, 0, 0, idle_o);

        // Reset state
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", cur(), idle_o);
        reset = 1'b0;

        // Table replay: one row per cycle, compared mid-cycle
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].vld, vecs[i].md, vecs[i].l, vecs[i].k, vecs[i].d, vecs[i].st);
            @(negedge clk);
            check($sformatf("row%0d", i), cur(), vecs[i].exp);
        end

        // Asynchronous reset in DRAIN abandons the command
        @(posedge clk); #1;
        drive(1, 0, 0, 0, 3, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("drain_before_reset", cur(), ws_drain);
        #1 reset = 1'b1;
        #1 check("async_reset", cur(), idle_o);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset_hold%0d", i), cur(), idle_o);
        end
        reset = 1'b0;
        @(negedge clk);
        check("after_reset_idle", cur(), idle_o);

        // BYPASS k=2 after reset
        @(posedge clk); #1;
        drive(1, 3, 0, 2, 0, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("bypass_c1", cur(), by_comp);
        @(negedge clk);
        check("bypass_c2", cur(), by_comp);
        @(negedge clk);
        check("bypass_done", cur(), done_o);
        @(negedge clk);
        check("bypass_idle", cur(), idle_o);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
